ro_sensor_scheduler: RTL and testbench
======================================

Name: ro_sensor_scheduler

Overview:
- Time-multiplexes a bank of NUM_RO ring-oscillator sensors, each a chain of dont_touch inverters, in round-robin order.
- Only one oscillator is enabled at a time, to limit self-heating and supply noise.
- For the selected oscillator: enable, let it settle, count rising edges of its divided output over a programmable window of clock cycles, then report one sample.
- Sits between the sensor macros and the hwdbg sensor readout logic.

Parameters:
- NUM_RO, 4, number of oscillators scheduled (1..16).
- WINDOW_W, 16, width of the measurement-window length.
- COUNT_W, 16, width of the edge counter and reported sample.
- SETTLE_CYCLES, 8, clock cycles between enable and start of counting (>=3).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start_i, input, 1, level sampled only in IDLE; begins a sweep.
- continuous_i, input, 1, when 1 at end of a sweep, wraps to RO 0 instead of going idle.
- window_i, input, WINDOW_W, measurement window in cycles; latched at sweep start.
- ro_div_i, input, NUM_RO, divided oscillator outputs; asynchronous to clock.
- ro_en_o, output, NUM_RO, one-hot oscillator enable.
- sample_valid_o, output, 1, one-cycle pulse, sample fields valid.
- sample_id_o, output, clog2(NUM_RO) (min 1), index of the reported oscillator.
- sample_count_o, output, COUNT_W, rising edges counted in the window.
- sample_ovf_o, output, 1, counter saturated during the window.
- busy_o, output, 1, high in any state other than IDLE.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values: all outputs 0, including ro_en_o. State IDLE, selected index 0, counters 0.
- Reset asserted mid-operation aborts the sweep immediately and emits no sample.
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE: with start_i=1 at edge t, latch window_eff = (window_i==0 ? 1 : window_i) and set idx=0.
  - Cycle t+1: SETTLE, ro_en_o[idx]=1, busy_o=1.
- SETTLE: lasts exactly SETTLE_CYCLES cycles.
  - Counter cleared; edges ignored.
  - The 2-FF synchroniser flushes stale data from the previous oscillator.
- MEASURE: lasts exactly window_eff cycles.
  - Edge = sync_q & ~sync_prev, where sync_q is the synchronised ro_div_i[idx] (mux before synchroniser) and sync_prev is a register tracked continuously.
  - Each edge increments the counter.
  - At max value (2^COUNT_W-1) the counter holds and sets ovf.
- REPORT: one cycle.
  - sample_valid_o=1, sample_id_o=idx, count and ovf presented.
  - Sample fields hold until the next REPORT.
  - ro_en_o stays on through REPORT; the transition enables the next oscillator directly, so exactly one enable bit is ever set.
- After REPORT:
  - idx<NUM_RO-1: idx+1, go to SETTLE.
  - idx==NUM_RO-1 and continuous_i=1: idx=0, go to SETTLE.
  - Otherwise: go to IDLE with ro_en_o=0.
- Per-oscillator period: SETTLE_CYCLES+window_eff+1 cycles.
- start_i is ignored outside IDLE. window_i changes mid-sweep take effect at the next sweep start only.
- Input bandwidth limit: ro_div_i frequency must be < clock/4 (integration requirement; above that, counts are undefined but never exceed saturation).
- NUM_RO=1: idx is always 0 and the wrap logic degenerates cleanly.

Decomposition:
- Shared package sensor_pkg:
  - State enum ro_sched_state_t.
  - Function for the id width.
  - Constant SYNC_STAGES=2.
- One natural sub-module: sync_edge_counter. It contains the 2-FF synchroniser, edge detect and saturating counter, with clear/enable inputs.
- The FSM and round-robin index live in the top module.

Test Plan:
- Reset checks: reset held with start_i=1 -> all outputs 0. Deassert reset; start_i=1 for one cycle -> busy_o and ro_en_o=4'b0001 on the next cycle.
- Counting: NUM_RO=4, SETTLE_CYCLES=8, window_i=100, ro_div_i[k] square wave of period 10*(k+1) cycles.
  - Four valid pulses with ids 0,1,2,3 and counts 10±1, 5±1, 3±1 (i.e. 2..4), 2..3.
  - Pulses spaced 109 cycles apart; busy_o drops one cycle after id 3.
- Saturation: COUNT_W=4, window_i=200, period-4 input -> sample_count_o=15, sample_ovf_o=1.
- Continuous mode: continuous_i=1 across a sweep end -> ids sequence 3,0 with no IDLE cycle. Drop continuous_i -> the sweep ends after id 3.
- Mid-operation events:
  - window_i=0 -> MEASURE lasts 1 cycle, REPORT is 2 cycles after SETTLE ends.
  - start_i pulsed during MEASURE -> ignored.
  - reset during MEASURE of id 2 -> no sample_valid_o; ro_en_o=0 on the next cycle.
- Enable invariant: assertion checks $onehot0(ro_en_o) on every cycle of every test.

Source files
------------

// File: rtl/ro_sensor_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the ring-oscillator sensor scheduler:
//   ro_sched_state_t - scheduler FSM states
//   SYNC_STAGES      - depth of the oscillator-input synchroniser
//   id_width()       - width of the oscillator index (never below 1 bit)
// -----------------------------------------------------------------------------
package sensor_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } ro_sched_state_t;

    // A single oscillator still needs a 1-bit id field.
    function automatic int id_width(input int num_ro);
        return (num_ro <= 1) ? 1 : $clog2(num_ro);
    endfunction

endpackage

// File: rtl/ro_sensor_scheduler_sync_edge_counter.sv
// -----------------------------------------------------------------------------
// sync_edge_counter
// Brings one asynchronous divided-oscillator signal into the clock domain,
// detects its rising edges and counts them with saturation.
//
// Ports:
//   clock          - system clock
//   reset          - synchronous active-high reset
//   i_async        - divided oscillator output (asynchronous)
//   i_clear        - zero the counter and overflow flag
//   i_enable       - count detected edges while high
//   o_count        - registered edge count
//   o_ovf          - registered overflow flag (an edge arrived at full scale)
//   o_count_next   - value o_count takes at the next edge
//   o_ovf_next     - value o_ovf takes at the next edge
// -----------------------------------------------------------------------------
module sync_edge_counter
    import sensor_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_async,
    input  logic               i_clear,
    input  logic               i_enable,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_ovf,
    output logic [COUNT_W-1:0] o_count_next,
    output logic               o_ovf_next
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [COUNT_W-1:0]     r_count;
    logic                   r_ovf;

    logic w_sync_q;
    logic w_edge;
    logic w_at_max;
    logic w_inc;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    // sync_prev follows the synchronised level every cycle, so the edge
    // detector is already primed when counting is enabled.
    assign w_edge   = w_sync_q & ~r_sync_prev;
    assign w_at_max = (r_count == {COUNT_W{1'b1}});
    assign w_inc    = i_enable & w_edge;

    assign o_count_next = (w_inc && !w_at_max) ? r_count + 1'b1 : r_count;
    assign o_ovf_next   = r_ovf | (w_inc & w_at_max);

    // NOTE: every register here is updated with <= so all flops sample the
    // pre-edge values; a blocking = would let the second synchroniser stage
    // see the first stage's new value in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_sync_prev <= w_sync_q;
            if (i_clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_count <= o_count_next;
                r_ovf   <= o_ovf_next;
            end
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/ro_sensor_scheduler.sv
// -----------------------------------------------------------------------------
// ro_sensor_scheduler
// Round-robin scheduler for a bank of ring-oscillator sensors. One oscillator
// is enabled at a time: it settles for SETTLE_CYCLES, its rising edges are
// counted over a window of window_eff cycles, then one sample is reported.
//
// Ports:
//   clock           - system clock
//   reset           - synchronous active-high reset
//   start_i         - begins a sweep (sampled only while idle)
//   continuous_i    - at the end of a sweep, wrap to oscillator 0
//   window_i        - measurement window in cycles (0 treated as 1)
//   ro_div_i        - divided oscillator outputs (asynchronous)
//   ro_en_o         - one-hot oscillator enable
//   sample_valid_o  - one-cycle pulse, sample fields valid
//   sample_id_o     - index of the reported oscillator
//   sample_count_o  - rising edges counted in the window
//   sample_ovf_o    - counter saturated during the window
//   busy_o          - high whenever not idle
// -----------------------------------------------------------------------------
module ro_sensor_scheduler
    import sensor_pkg::*;
#(
    parameter int NUM_RO        = 4,
    parameter int WINDOW_W      = 16,
    parameter int COUNT_W       = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic                          continuous_i,
    input  logic [WINDOW_W-1:0]           window_i,
    input  logic [NUM_RO-1:0]             ro_div_i,
    output logic [NUM_RO-1:0]             ro_en_o,
    output logic                          sample_valid_o,
    output logic [id_width(NUM_RO)-1:0]   sample_id_o,
    output logic [COUNT_W-1:0]            sample_count_o,
    output logic                          sample_ovf_o,
    output logic                          busy_o
);

    localparam int ID_W     = id_width(NUM_RO);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    // One timer serves both the settle phase and the measurement window.
    localparam int TIMER_W  = (WINDOW_W > SETTLE_W) ? WINDOW_W : SETTLE_W;

    ro_sched_state_t     r_state;
    logic [ID_W-1:0]     r_idx;
    logic [WINDOW_W-1:0] r_window;
    logic [TIMER_W-1:0]  r_timer;
    logic [NUM_RO-1:0]   r_ro_en;
    logic                r_valid;
    logic [ID_W-1:0]     r_id;
    logic [COUNT_W-1:0]  r_count;
    logic                r_ovf;
    logic                r_busy;

    logic                w_ro_sel;
    logic                w_cnt_clear;
    logic                w_cnt_enable;
    logic [COUNT_W-1:0]  w_cnt;
    logic                w_ovf;
    logic [COUNT_W-1:0]  w_cnt_next;
    logic                w_ovf_next;
    logic                w_settle_done;
    logic                w_window_done;
    logic                w_last_idx;
    logic [ID_W-1:0]     w_idx_inc;

    // The oscillator is selected before the synchroniser, so the settle
    // phase flushes the previous oscillator's level out of the sync chain.
    assign w_ro_sel     = ro_div_i[r_idx];
    assign w_cnt_clear  = (r_state == ST_SETTLE);
    assign w_cnt_enable = (r_state == ST_MEASURE);

    assign w_settle_done = (r_timer == TIMER_W'(SETTLE_CYCLES - 1));
    assign w_window_done = (r_timer == TIMER_W'(r_window - 1'b1));
    assign w_last_idx    = (r_idx == ID_W'(NUM_RO - 1));
    assign w_idx_inc     = r_idx + 1'b1;

    sync_edge_counter #(
        .COUNT_W (COUNT_W)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .i_async      (w_ro_sel),
        .i_clear      (w_cnt_clear),
        .i_enable     (w_cnt_enable),
        .o_count      (w_cnt),
        .o_ovf        (w_ovf),
        .o_count_next (w_cnt_next),
        .o_ovf_next   (w_ovf_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_window <= '0;
            r_timer  <= '0;
            r_ro_en  <= '0;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_window <= (window_i == '0) ? WINDOW_W'(1) : window_i;
                        r_idx    <= '0;
                        r_timer  <= '0;
                        r_ro_en  <= NUM_RO'(1);
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (w_settle_done) begin
                        r_timer <= '0;
                        r_state <= ST_MEASURE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_MEASURE: begin
                    if (w_window_done) begin
                        // Capture the count including the last window cycle.
                        r_valid <= 1'b1;
                        r_id    <= r_idx;
                        r_count <= w_cnt_next;
                        r_ovf   <= w_ovf_next;
                        r_state <= ST_REPORT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_REPORT: begin
                    r_timer <= '0;
                    // Enable moves straight to the next oscillator so at most
                    // one enable bit is ever set.
                    if (!w_last_idx) begin
                        r_idx   <= w_idx_inc;
                        r_ro_en <= NUM_RO'(1) << w_idx_inc;
                        r_state <= ST_SETTLE;
                    end else if (continuous_i) begin
                        r_idx   <= '0;
                        r_ro_en <= NUM_RO'(1);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_idx   <= '0;
                        r_ro_en <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_ro_en <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ro_en_o        = r_ro_en;
    assign sample_valid_o = r_valid;
    assign sample_id_o    = r_id;
    assign sample_count_o = r_count;
    assign sample_ovf_o   = r_ovf;
    assign busy_o         = r_busy;

    // Registered copies are reported; the live counter state is unused here.
    logic w_unused;
    assign w_unused = ^{w_cnt, w_ovf};

endmodule

// File: tb/tb_ro_sensor_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ro_sensor_scheduler
// Directed bench for ro_sensor_scheduler. A second instance with a 4-bit
// counter exercises saturation. Oscillator k toggles with period 10*(k+1).
// -----------------------------------------------------------------------------
module tb_ro_sensor_scheduler;

    localparam int NUM_RO   = 4;
    localparam int WINDOW_W = 16;
    localparam int COUNT_W  = 16;
    localparam int SAT_W    = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic                start_i;
    logic                continuous_i;
    logic [WINDOW_W-1:0] window_i;
    logic [NUM_RO-1:0]   ro_div_i;
    logic [NUM_RO-1:0]   ro_en_o;
    logic                sample_valid_o;
    logic [1:0]          sample_id_o;
    logic [COUNT_W-1:0]  sample_count_o;
    logic                sample_ovf_o;
    logic                busy_o;

    logic                start_s;
    logic [WINDOW_W-1:0] window_s;
    logic [NUM_RO-1:0]   ro_div_s;
    logic [NUM_RO-1:0]   ro_en_s;
    logic                valid_s;
    logic [1:0]          id_s;
    logic [SAT_W-1:0]    count_s;
    logic                ovf_s;
    logic                busy_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ro_sensor_scheduler #(
        .NUM_RO(NUM_RO), .WINDOW_W(WINDOW_W), .COUNT_W(COUNT_W), .SETTLE_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .start_i(start_i), .continuous_i(continuous_i),
        .window_i(window_i), .ro_div_i(ro_div_i), .ro_en_o(ro_en_o),
        .sample_valid_o(sample_valid_o), .sample_id_o(sample_id_o),
        .sample_count_o(sample_count_o), .sample_ovf_o(sample_ovf_o), .busy_o(busy_o)
    );

    ro_sensor_scheduler #(
        .NUM_RO(NUM_RO), .WINDOW_W(WINDOW_W), .COUNT_W(SAT_W), .SETTLE_CYCLES(8)
    ) dut_sat (
        .clock(clock), .reset(reset), .start_i(start_s), .continuous_i(1'b0),
        .window_i(window_s), .ro_div_i(ro_div_s), .ro_en_o(ro_en_s),
        .sample_valid_o(valid_s), .sample_id_o(id_s),
        .sample_count_o(count_s), .sample_ovf_o(ovf_s), .busy_o(busy_s)
    );

    always #5 clock = ~clock;

    // Oscillator stand-ins, changing on the falling edge.
    initial begin
        ro_div_i = '0;
        ro_div_s = '0;
        forever begin
            @(negedge clock);
            cyc = cyc + 1;
            for (int k = 0; k < NUM_RO; k++)
                ro_div_i[k] = ((cyc % (10 * (k + 1))) < (5 * (k + 1)));
            ro_div_s = {3'b000, ((cyc % 4) < 2)};
        end
    end

    // At most one oscillator enabled, every cycle, on both instances.
    initial begin
        forever begin
            @(negedge clock);
            assert ($onehot0(ro_en_o) && $onehot0(ro_en_s)) else begin
                n_fail++;
                $error("FAIL onehot_en: observed %b/%b expected at most one bit set", ro_en_o, ro_en_s);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs,
                               input logic [31:0] lo, input logic [31:0] hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for a sample pulse on the main (sel=0) or saturating (sel=1) instance.
    task automatic wait_valid(input bit sel, input int budget);
        int waited;
        waited = 0;
        while (((sel ? valid_s : sample_valid_o) !== 1'b1) && waited < budget) begin
            tick();
            waited++;
        end
        check(sel ? "valid_seen_sat" : "valid_seen", 32'(sel ? valid_s : sample_valid_o), 32'd1);
    endtask

    int          t0;
    int          t_prev;
    int          seen;
    logic [3:0]  exp_en;
    logic [31:0] lo_tab [4] = '{32'd9, 32'd4, 32'd2, 32'd2};
    logic [31:0] hi_tab [4] = '{32'd11, 32'd6, 32'd4, 32'd3};

    initial begin
        reset        = 1'b1;
        start_i      = 1'b1;
        continuous_i = 1'b0;
        window_i     = 16'd100;
        start_s      = 1'b0;
        window_s     = 16'd200;

        // Reset held with start asserted: everything quiet.
        repeat (3) tick();
        check("rst_ro_en",  32'(ro_en_o), 32'd0);
        check("rst_valid",  32'(sample_valid_o), 32'd0);
        check("rst_id",     32'(sample_id_o), 32'd0);
        check("rst_count",  32'(sample_count_o), 32'd0);
        check("rst_ovf",    32'(sample_ovf_o), 32'd0);
        check("rst_busy",   32'(busy_o), 32'd0);
        check("rst_ro_en_sat", 32'(ro_en_s), 32'd0);

        // Release reset with start high for one cycle.
        reset = 1'b0;
        tick();
        start_i = 1'b0;
        t0 = cyc;
        check("start_busy",  32'(busy_o), 32'd1);
        check("start_ro_en", 32'(ro_en_o), 32'd1);

        // Start pulse and window change mid-sweep must both be ignored.
        repeat (20) tick();
        check("measure_ro_en", 32'(ro_en_o), 32'd1);
        start_i  = 1'b1;
        window_i = 16'd50;
        tick();
        start_i = 1'b0;

        t_prev = t0;
        for (int k = 0; k < NUM_RO; k++) begin
            wait_valid(1'b0, 200);
            exp_en = 4'(1 << k);
            check("sweep_id",    32'(sample_id_o), 32'(k));
            check_range("sweep_count", 32'(sample_count_o), lo_tab[k], hi_tab[k]);
            check("sweep_ovf",   32'(sample_ovf_o), 32'd0);
            check("report_ro_en", 32'(ro_en_o), 32'(exp_en));
            check("sweep_spacing", 32'(cyc - t_prev), (k == 0) ? 32'd108 : 32'd109);
            t_prev = cyc;
            tick();
        end
        check("end_busy",  32'(busy_o), 32'd0);
        check("end_ro_en", 32'(ro_en_o), 32'd0);
        check("end_valid", 32'(sample_valid_o), 32'd0);
        check("hold_id",   32'(sample_id_o), 32'd3);

        // Saturation with a 4-bit counter, then a quiet oscillator clears ovf.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        t0 = cyc;
        wait_valid(1'b1, 300);
        check("sat_id",      32'(id_s), 32'd0);
        check("sat_count",   32'(count_s), 32'd15);
        check("sat_ovf",     32'(ovf_s), 32'd1);
        check("sat_latency", 32'(cyc - t0), 32'd208);
        tick();
        wait_valid(1'b1, 300);
        check("sat_next_id",    32'(id_s), 32'd1);
        check("sat_next_count", 32'(count_s), 32'd0);
        check("sat_next_ovf",   32'(ovf_s), 32'd0);

        // window_i=0 acts as 1; continuous mode wraps 3 -> 0 without idling.
        window_i     = 16'd0;
        continuous_i = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        t_prev = cyc;
        for (int k = 0; k < NUM_RO; k++) begin
            wait_valid(1'b0, 50);
            check("cont_id", 32'(sample_id_o), 32'(k));
            check("cont_spacing", 32'(cyc - t_prev), (k == 0) ? 32'd9 : 32'd10);
            t_prev = cyc;
            tick();
        end
        check("wrap_busy",  32'(busy_o), 32'd1);
        check("wrap_ro_en", 32'(ro_en_o), 32'd1);
        wait_valid(1'b0, 50);
        check("wrap_id",      32'(sample_id_o), 32'd0);
        check("wrap_spacing", 32'(cyc - t_prev), 32'd10);
        t_prev = cyc;
        continuous_i = 1'b0;
        tick();
        for (int k = 1; k < NUM_RO; k++) begin
            wait_valid(1'b0, 50);
            check("cont2_id", 32'(sample_id_o), 32'(k));
            check("cont2_spacing", 32'(cyc - t_prev), 32'd10);
            t_prev = cyc;
            tick();
        end
        check("cont_end_busy",  32'(busy_o), 32'd0);
        check("cont_end_ro_en", 32'(ro_en_o), 32'd0);

        // Reset during the measurement of oscillator 2 aborts silently.
        window_i = 16'd100;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        wait_valid(1'b0, 200);
        tick();
        wait_valid(1'b0, 200);
        check("abort_pre_id", 32'(sample_id_o), 32'd1);
        repeat (30) tick();
        check("abort_pre_ro_en", 32'(ro_en_o), 32'd4);
        reset = 1'b1;
        tick();
        check("abort_ro_en", 32'(ro_en_o), 32'd0);
        check("abort_busy",  32'(busy_o), 32'd0);
        check("abort_valid", 32'(sample_valid_o), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (150) begin
            tick();
            if (sample_valid_o === 1'b1) seen++;
        end
        check("abort_no_sample", 32'(seen), 32'd0);
        check("abort_idle_ro_en", 32'(ro_en_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
